// File: rtl/vga_vram_scanout.sv
// VGA 640x480@60 raster generator that scans an IMG_W x IMG_H grayscale image out of VRAM.
// Three-stage pipeline: counters -> registered VRAM address/flags -> registered pixel and syncs.
module vga_vram_scanout #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned IMG_W     = 256,
    parameter int unsigned IMG_H     = 256,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [7:0]        vram_data,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic [7:0]        rgb_out,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [31:0]       x;
    logic [31:0]       y;
    logic              h_last;
    logic              v_last;
    logic              visible0;
    logic              in_img0;
    logic              hs0;
    logic              vs0;
    logic              first0;
    logic              visible1;
    logic              in_img1;
    logic              hs1;
    logic              vs1;
    logic              first1;
    logic [ADDR_W-1:0] addr_ptr;

    // Stage 0 decode; "x+1 <= N" form keeps zero-sized images legal without a compare against 0.
    always_comb begin
        x        = 32'(h_cnt);
        y        = 32'(v_cnt);
        h_last   = (x == H_TOTAL - 1);
        v_last   = (y == V_TOTAL - 1);
        visible0 = (x < H_VISIBLE) && (y < V_VISIBLE);
        in_img0  = visible0 && ((x + 32'd1) <= IMG_W) && ((y + 32'd1) <= IMG_H);
        hs0      = !((x >= H_VISIBLE + H_FP) && (x < H_VISIBLE + H_FP + H_SYNC));
        vs0      = !((y >= V_VISIBLE + V_FP) && (y < V_VISIBLE + V_FP + V_SYNC));
        first0   = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Incremental address walk; the pointer rewinds at (0,0) so every frame starts at BASE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_addr <= BASE;
            addr_ptr  <= BASE;
        end else if (pix_en) begin
            if (first0) begin
                if (in_img0) begin
                    vram_addr <= BASE;
                    addr_ptr  <= BASE + 1'b1;
                end else begin
                    addr_ptr  <= BASE;
                end
            end else if (in_img0) begin
                vram_addr <= addr_ptr;
                addr_ptr  <= addr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            visible1 <= 1'b0;
            in_img1  <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            first1   <= 1'b0;
        end else if (pix_en) begin
            visible1 <= visible0;
            in_img1  <= in_img0;
            hs1      <= hs0;
            vs1      <= vs0;
            first1   <= first0;
        end
    end

    // frame_start is rewritten every clk so it can never stretch across disabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && first1;
            if (pix_en) begin
                rgb_out <= in_img1 ? vram_data : 8'd0;
                hsync   <= hs1;
                vsync   <= vs1;
                blank_n <= visible1;
            end
        end
    end

endmodule

// File: tb/tb_vga_vram_scanout.sv
// Scoreboard bench for vga_vram_scanout on a reduced raster with three image configurations:
// in-bounds image, oversize image clamped by the visible area, and zero-width image.
module tb_vga_vram_scanout;

    localparam int unsigned HV = 20;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned VV = 12;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [31:0] addr [3];
    logic [7:0]  data [3];
    logic [7:0]  rgb  [3];
    logic        hs   [3];
    logic        vs   [3];
    logic        bn   [3];
    logic        fs   [3];

    always #5 clk = ~clk;

    // VRAM model: read data follows the registered address, pixel value = address low byte.
    assign data[0] = addr[0][7:0];
    assign data[1] = addr[1][7:0];
    assign data[2] = addr[2][7:0];

    vga_vram_scanout #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(8), .IMG_H(6), .BASE_ADDR(0), .ADDR_W(32)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vram_data(data[0]),
        .vram_addr(addr[0]), .hsync(hs[0]), .vsync(vs[0]), .blank_n(bn[0]),
        .rgb_out(rgb[0]), .frame_start(fs[0])
    );

    vga_vram_scanout #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(32), .IMG_H(20), .BASE_ADDR(1000), .ADDR_W(32)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vram_data(data[1]),
        .vram_addr(addr[1]), .hsync(hs[1]), .vsync(vs[1]), .blank_n(bn[1]),
        .rgb_out(rgb[1]), .frame_start(fs[1])
    );

    vga_vram_scanout #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(0), .IMG_H(6), .BASE_ADDR(5), .ADDR_W(32)
    ) dut_c (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vram_data(data[2]),
        .vram_addr(addr[2]), .hsync(hs[2]), .vsync(vs[2]), .blank_n(bn[2]),
        .rgb_out(rgb[2]), .frame_start(fs[2])
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] pos_q[$];
    int unsigned px = 0;
    int unsigned py = 0;
    logic [11:0] last_exp [3];
    bit          have_last = 0;
    int          en_ticks = 0;
    int          last_fs_tick = -1;
    int          fs_seen = 0;
    int          fs_expected = 0;
    int          frames_started = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned dut_w(input int i);
        case (i)
            0: return 8;
            1: return 32;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned dut_h(input int i);
        return (i == 1) ? 20 : 6;
    endfunction

    function automatic int unsigned dut_base(input int i);
        case (i)
            0: return 0;
            1: return 1000;
            default: return 5;
        endcase
    endfunction

    function automatic int unsigned dut_last(input int i);
        case (i)
            0: return 47;      // 8*6-1
            1: return 1239;    // 1000 + 20*12 - 1 (clamped to the visible area)
            default: return 5; // empty image never moves off BASE
        endcase
    endfunction

    // Expected {frame_start, hsync, vsync, blank_n, rgb} for output pixel (x,y).
    function automatic logic [11:0] expect_out(input int unsigned x, input int unsigned y, input int i,
                                               input logic f);
        int unsigned w;
        int unsigned weff;
        logic        vis;
        logic        img;
        logic [31:0] a;
        logic [7:0]  pix;
        w    = dut_w(i);
        weff = (w < HV) ? w : HV;
        vis  = (x < HV) && (y < VV);
        img  = vis && (x < w) && (y < dut_h(i));
        a    = dut_base(i) + y * weff + x;
        pix  = img ? a[7:0] : 8'd0;
        return {f, !((x >= HV + HF) && (x < HV + HF + HS)), !((y >= VV + VF) && (y < VV + VF + VS)), vis, pix};
    endfunction

    function automatic logic [11:0] observed(input int i);
        return {fs[i], hs[i], vs[i], bn[i], rgb[i]};
    endfunction

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_addr%0d", tag, i), addr[i], dut_base(i));
            check($sformatf("%s_out%0d", tag, i), 32'(observed(i)), 32'(12'b0110_0000_0000));
        end
    endtask

    task automatic tick(input logic en);
        logic [31:0] p;
        logic [11:0] e;
        bit          at_origin;
        pix_en = en;
        at_origin = en && (px == 0) && (py == 0);
        if (at_origin && frames_started > 0)
            for (int i = 0; i < 3; i++)
                check($sformatf("last_addr%0d", i), addr[i], dut_last(i));
        @(posedge clk);
        if (en) begin
            en_ticks++;
            pos_q.push_back({py[15:0], px[15:0]});
            if (px == HT - 1) begin
                px = 0;
                py = (py == VT - 1) ? 0 : py + 1;
            end else begin
                px++;
            end
        end
        #1;
        if (at_origin) begin
            frames_started++;
            for (int i = 0; i < 3; i++)
                check($sformatf("first_addr%0d", i), addr[i], dut_base(i));
        end
        if (en) begin
            if (pos_q.size() >= 2) begin
                p = pos_q.pop_front();
                if (p == 0) fs_expected++;
                for (int i = 0; i < 3; i++) begin
                    e = expect_out(int'(p[15:0]), int'(p[31:16]), i, p == 0);
                    check($sformatf("out%0d_x%0d_y%0d", i, p[15:0], p[31:16]), 32'(observed(i)), 32'(e));
                    last_exp[i] = e;
                end
                have_last = 1;
            end
        end else if (have_last) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("hold%0d", i), 32'(observed(i)), 32'({1'b0, last_exp[i][10:0]}));
        end
        if (fs[0] === 1'b1) begin
            fs_seen++;
            if (last_fs_tick >= 0)
                check("frame_period", 32'(en_ticks - last_fs_tick), HT * VT);
            last_fs_tick = en_ticks;
        end
    endtask

    task automatic restart_model();
        pos_q.delete();
        px = 0;
        py = 0;
        have_last = 0;
        last_fs_tick = -1;
        frames_started = 0;
    endtask

    initial begin
        bit found;
        reset  = 1'b1;
        pix_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        // Two frames at full pixel rate, plus a few ticks to see the third frame begin.
        for (int n = 0; n < 2 * HT * VT + 4; n++) tick(1'b1);

        // One frame with pix_en on every other clk.
        for (int n = 0; n < 2 * HT * VT; n++) tick(n[0] == 1'b0);

        // Walk to counter position (10,5), then reset mid-frame.
        found = 0;
        for (int n = 0; n < HT * VT && !found; n++) begin
            if (px == 10 && py == 5) found = 1;
            else tick(1'b1);
        end
        check("reach_mid_frame", 32'(found), 32'd1);
        #3 reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        restart_model();
        for (int n = 0; n < HT * VT + 4; n++) tick(1'b1);

        check("frame_start_count", 32'(fs_seen), 32'(fs_expected));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_vram_scanout.md
Name: vga_vram_scanout

Overview:
- Display-side consumer of the processor's video RAM read port (8-bit grayscale pixels).
- Generates 640x480@60 VGA timing and walks VRAM addresses in raster order.
- Aligns the 1-cycle VRAM read data with the sync and blanking signals and drives `rgb_out`.
- Places an IMG_W x IMG_H image at the top-left of the screen; all other visible pixels are black.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in lines
- BASE_ADDR, 0, VRAM address of image pixel (0,0)
- ADDR_W, 32, VRAM address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-rate enable; all state advances only when 1
- vram_data  in  8  VRAM read data; valid 1 clk after `vram_addr` changes
- vram_addr  out  ADDR_W  registered VRAM read address
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank_n  out  1  1 while output pixel is in the visible area
- rgb_out  out  8  grayscale pixel; 0 outside the image or during blanking
- frame_start  out  1  single-clk pulse aligned with output pixel (0,0)

Behaviour:
- Reset (async, any time, including mid-frame):
  - h_cnt = 0, v_cnt = 0, pipeline flags cleared.
  - Outputs: `vram_addr` = BASE_ADDR, `hsync` = 1, `vsync` = 1, `blank_n` = 0, `rgb_out` = 0, `frame_start` = 0.
  - After release, the first pix_en tick processes position (0,0).
- Counters:
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL = 800); v_cnt counts 0..V_TOTAL-1 (V_TOTAL = 525).
  - h_cnt wraps to 0 and v_cnt increments when h_cnt == H_TOTAL-1.
  - v_cnt wraps to 0 after line V_TOTAL-1.
  - With pix_en = 0, every register holds.
- Stage 0 (counter position (x,y)):
  - visible = x < H_VISIBLE && y < V_VISIBLE.
  - in_img = x < IMG_W && y < IMG_H.
  - hs_raw = 0 when H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 when V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC (490..491).
- Address generation (no multiplier; incremental):
  - On a pix_en tick where stage 0 is in_img, register `vram_addr` <= addr_ptr, then addr_ptr++.
  - addr_ptr resets to BASE_ADDR when stage 0 is at (0,0), so every frame re-reads from BASE_ADDR.
  - Outside in_img, `vram_addr` holds its last value.
  - The last image pixel reads BASE_ADDR + IMG_W*IMG_H - 1 (65535 at defaults).
- Stage 1: visible, in_img, hs_raw, vs_raw and first flags are registered alongside `vram_addr`.
- Stage 2 (outputs, registered on pix_en):
  - `rgb_out` = stage-1 in_img ? `vram_data` : 0.
  - `hsync`, `vsync` and `blank_n` come from stage 1.
  - `frame_start` = 1 for exactly one clk when stage 1 holds (0,0) and pix_en = 1; 0 otherwise.
- Latency: 2 pix_en ticks from counter position to outputs; sync, blank and pixel data are always mutually aligned.
- Size clamping:
  - IMG_W > H_VISIBLE or IMG_H > V_VISIBLE: in_img is clamped by visible.
  - IMG_W = 0 or IMG_H = 0: screen is all black and `vram_addr` stays at BASE_ADDR.
- pix_en asserted every clk is legal (`vram_data` is registered 1 clk after the address).

Test Plan:
- Reset mid-frame (at h=300, v=100) -> outputs return to reset values immediately; the first output pixel after release is (0,0) with `frame_start` = 1, two pix_en ticks later.
- pix_en every clk, VRAM model returns addr[7:0], full frame -> 420000 ticks/frame; `rgb_out` at output pixel (x,y) inside 256x256 equals (y*256+x)&255; outside the image `rgb_out` = 0.
- hsync/vsync timing -> `hsync` low exactly for output x = 656..751 (96 ticks); `vsync` low exactly for lines 490..491; `blank_n` = 0 for x >= 640 or y >= 480.
- pix_en toggling (1 of every 2 clks) -> identical output sequence to the previous scenario on enabled cycles; all outputs hold on disabled cycles.
- Two consecutive frames -> `vram_addr` sequence restarts at BASE_ADDR; the last address in each frame is 65535; exactly one `frame_start` pulse per frame.
- IMG_W = 640, IMG_H = 480, BASE_ADDR = 1000 -> first address 1000, last 308199; every visible pixel is sourced from VRAM.
